// File: rtl/seq_serializer_pkg.sv
// Shared definitions for the parallel-to-serial front end:
// FSM state encoding and the bit-counter width helper.
package seq_serializer_pkg;

  // Two-bit encoding leaves spare codes; any of them falls back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01
  } state_t;

  // Width of the per-word bit counter (counts 0..width-1).
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_serializer.sv
// Parallel-to-serial converter with a one-entry holding register so that
// back-to-back words leave as a gap-free bit stream.
//
// Handshake: a word is taken on a rising edge where load_valid && load_ready;
// load_ready depends only on registered state (low while the hold register is
// full or reset is high). On the serial side, ser_valid marks a bit that the
// downstream consumes this cycle (shift_en high while a word is in the shifter);
// when shift_en is low the current bit is held on ser_out.
module seq_serializer
  import seq_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output logic [1:0]       dbg_state_o
);

  localparam int               CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q;
  logic [WIDTH-1:0] shift_reg_q;
  logic [WIDTH-1:0] hold_reg_q;
  logic             hold_full_q;
  logic [CNT_W-1:0] bit_cnt_q;

  logic             in_shift;
  logic             head_bit;
  logic             last_bit;
  logic             accept;
  logic [WIDTH-1:0] shifted_d;

  // Output decode and handshake qualifiers, all forced low while reset is high.
  always_comb begin
    in_shift    = (state_q == ST_SHIFT);
    head_bit    = MSB_FIRST ? shift_reg_q[WIDTH-1] : shift_reg_q[0];
    last_bit    = (bit_cnt_q == LAST_CNT);
    shifted_d   = MSB_FIRST ? {shift_reg_q[WIDTH-2:0], 1'b0}
                            : {1'b0, shift_reg_q[WIDTH-1:1]};
    load_ready  = !reset && !hold_full_q;
    accept      = load_valid && load_ready;
    ser_valid   = !reset && in_shift && shift_en;
    ser_out     = !reset && in_shift && head_bit;
    word_done   = ser_valid && last_bit;
    dbg_state_o = state_q;
  end

  // Control FSM plus shifter, hold register and bit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shift_reg_q <= '0;
      hold_reg_q  <= '0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Hold register is always empty here, so a new word goes straight
          // into the shifter and its first bit shows up next cycle.
          if (accept) begin
            shift_reg_q <= data_in;
            bit_cnt_q   <= '0;
            state_q     <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (shift_en && last_bit) begin
            // Final bit leaves now: refill from hold, else from a word
            // arriving this very cycle, else fall back to IDLE.
            bit_cnt_q <= '0;
            if (hold_full_q) begin
              shift_reg_q <= hold_reg_q;
              hold_full_q <= 1'b0;
            end else if (accept) begin
              shift_reg_q <= data_in;
            end else begin
              shift_reg_q <= shifted_d;
              state_q     <= ST_IDLE;
            end
          end else begin
            if (shift_en) begin
              shift_reg_q <= shifted_d;
              bit_cnt_q   <= bit_cnt_q + CNT_ONE;
            end
            // A word offered mid-shift (or during a stall) parks in hold.
            if (accept) begin
              hold_reg_q  <= data_in;
              hold_full_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          hold_full_q <= 1'b0;
          bit_cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: directed vector tables, hand-written corner
// sequences, and a randomized run scored against a word-queue model.
module tb_seq_serializer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // 8-bit MSB-first instance
  logic       lv8 = 1'b0, se8 = 1'b0;
  logic [7:0] d8 = '0;
  logic       lr8, so8, sv8, wd8;
  logic [1:0] st8;

  // 4-bit LSB-first instance
  logic       lv4 = 1'b0, se4 = 1'b0;
  logic [3:0] d4 = '0;
  logic       lr4, so4, sv4, wd4;
  logic [1:0] st4;

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
    .clk(clk), .reset(reset), .data_in(d8), .load_valid(lv8),
    .load_ready(lr8), .shift_en(se8), .ser_out(so8), .ser_valid(sv8),
    .word_done(wd8), .dbg_state_o(st8)
  );

  seq_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut4 (
    .clk(clk), .reset(reset), .data_in(d4), .load_valid(lv4),
    .load_ready(lr4), .shift_en(se4), .ser_out(so4), .ser_valid(sv4),
    .word_done(wd4), .dbg_state_o(st4)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];   // accepted words not yet fully consumed
  int         bit_idx;    // bits of exp_q[0] already consumed

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive on the falling edge, then let combinational outputs settle.
  task automatic cyc8(input logic lv, input logic [7:0] d, input logic se);
    @(negedge clk);
    lv8 = lv; d8 = d; se8 = se;
    #1;
  endtask

  task automatic cyc4(input logic lv, input logic [3:0] d, input logic se);
    @(negedge clk);
    lv4 = lv; d4 = d; se4 = se;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    lv8 = 1'b0; se8 = 1'b0; lv4 = 1'b0; se4 = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready8", lr8, 0);
    chk("rst_valid8", sv8, 0);
    chk("rst_out8",   so8, 0);
    chk("rst_done8",  wd8, 0);
    chk("rst_state8", st8, 0);
    chk("rst_ready4", lr4, 0);
    chk("rst_valid4", sv4, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready8", lr8, 1);
    chk("post_rst_ready4", lr4, 1);
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic [7:0] word;
    logic [7:0] stream;  // bits in send order, first bit at [7]
  } vec8_t;

  typedef struct {
    logic [3:0] word;
    logic [3:0] stream;  // bits in send order, first bit at [3]
  } vec4_t;

  vec8_t tab8[4];
  vec4_t tab4[3];

  initial begin
    logic [15:0] got;
    logic [10:0] se_pat;
    logic [10:0] out_pat;
    logic [7:0]  fw;
    logic        lv, se, exp_lr, exp_sv;
    logic [7:0]  d;

    tab8[0] = '{word: 8'hA5, stream: 8'b10100101};
    tab8[1] = '{word: 8'h01, stream: 8'b00000001};
    tab8[2] = '{word: 8'h80, stream: 8'b10000000};
    tab8[3] = '{word: 8'h3C, stream: 8'b00111100};
    tab4[0] = '{word: 4'hA, stream: 4'b0101};
    tab4[1] = '{word: 4'h1, stream: 4'b1000};
    tab4[2] = '{word: 4'hC, stream: 4'b0011};

    do_reset();

    // Single words, MSB first, shift_en held high.
    foreach (tab8[r]) begin
      cyc8(1'b1, tab8[r].word, 1'b1);
      chk("t8_accept_ready", lr8, 1);
      chk("t8_accept_valid", sv8, 0);
      for (int i = 0; i < 8; i++) begin
        cyc8(1'b0, 8'h00, 1'b1);
        chk("t8_valid", sv8, 1);
        chk("t8_bit",   so8, tab8[r].stream[7-i]);
        chk("t8_done",  wd8, (i == 7));
      end
      cyc8(1'b0, 8'h00, 1'b1);
      chk("t8_idle_valid", sv8, 0);
    end

    // Single words, 4-bit LSB first.
    foreach (tab4[r]) begin
      cyc4(1'b1, tab4[r].word, 1'b1);
      chk("t4_accept_ready", lr4, 1);
      for (int i = 0; i < 4; i++) begin
        cyc4(1'b0, 4'h0, 1'b1);
        chk("t4_valid", sv4, 1);
        chk("t4_bit",   so4, tab4[r].stream[3-i]);
        chk("t4_done",  wd4, (i == 3));
      end
      for (int i = 0; i < 2; i++) begin
        cyc4(1'b0, 4'h0, 1'b1);
        chk("t4_idle_valid", sv4, 0);
      end
    end

    // AA then 55 two cycles later: 16 contiguous bits via the hold register.
    cyc8(1'b1, 8'hAA, 1'b1);
    got = '0;
    for (int c = 1; c <= 16; c++) begin
      cyc8(c == 2, 8'h55, 1'b1);
      if (c == 2) chk("b2b_second_ready", lr8, 1);
      chk("b2b_valid", sv8, 1);
      chk("b2b_done", wd8, (c == 8 || c == 16));
      if (c >= 3 && c <= 8) chk("b2b_ready_low", lr8, 0);
      if (c == 9) chk("b2b_ready_back", lr8, 1);
      got = {got[14:0], so8};
    end
    chk("b2b_stream", got, 16'b1010101001010101);
    cyc8(1'b0, 8'h00, 1'b1);
    chk("b2b_idle", sv8, 0);

    // F0 with a 3-cycle stall after bit 3.
    se_pat  = 11'b11110001111;
    out_pat = 11'b11110000000;
    cyc8(1'b1, 8'hF0, 1'b1);
    for (int c = 0; c < 11; c++) begin
      cyc8(1'b0, 8'h00, se_pat[10-c]);
      chk("stall_valid", sv8, se_pat[10-c]);
      chk("stall_bit",   so8, out_pat[10-c]);
      chk("stall_done",  wd8, (c == 10));
    end
    cyc8(1'b0, 8'h00, 1'b1);
    chk("stall_idle", sv8, 0);

    // FF then 0F offered exactly on FF's last-bit cycle with hold empty.
    cyc8(1'b1, 8'hFF, 1'b1);
    got = '0;
    for (int c = 1; c <= 16; c++) begin
      cyc8(c == 8, 8'h0F, 1'b1);
      if (c == 8) chk("direct_ready", lr8, 1);
      chk("direct_valid", sv8, 1);
      chk("direct_done", wd8, (c == 8 || c == 16));
      got = {got[14:0], so8};
    end
    chk("direct_stream", got, 16'hFF0F);
    cyc8(1'b0, 8'h00, 1'b1);
    chk("direct_idle", sv8, 0);

    // Asynchronous reset in the middle of A5.
    cyc8(1'b1, 8'hA5, 1'b1);
    cyc8(1'b0, 8'h00, 1'b1);
    cyc8(1'b0, 8'h00, 1'b1);
    cyc8(1'b0, 8'h00, 1'b1);
    chk("arst_pre_bit", so8, 1);
    chk("arst_pre_valid", sv8, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", sv8, 0);
    chk("arst_out",   so8, 0);
    chk("arst_done",  wd8, 0);
    chk("arst_ready", lr8, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst_rel_ready", lr8, 1);
    chk("arst_rel_state", st8, 0);
    for (int c = 0; c < 10; c++) begin
      cyc8(1'b0, 8'h00, 1'b1);
      chk("arst_no_done",  wd8, 0);
      chk("arst_no_valid", sv8, 0);
    end

    // Randomized traffic against the word-queue model.
    do_reset();
    exp_q.delete();
    bit_idx = 0;
    for (int n = 0; n < 3000; n++) begin
      lv = 1'($urandom_range(0, 1));
      se = ($urandom_range(0, 3) != 0);
      d  = 8'($urandom);
      cyc8(lv, d, se);
      exp_lr = (exp_q.size() < 2);
      exp_sv = se && (exp_q.size() > 0);
      chk("rnd_ready", lr8, exp_lr);
      chk("rnd_valid", sv8, exp_sv);
      chk("rnd_done",  wd8, exp_sv && (bit_idx == 7));
      if (exp_q.size() > 0) begin
        fw = exp_q[0];
        chk("rnd_bit", so8, fw[7-bit_idx]);
      end
      if (exp_sv) begin
        bit_idx++;
        if (bit_idx == 8) begin
          void'(exp_q.pop_front());
          bit_idx = 0;
        end
      end
      if (lv && exp_lr) exp_q.push_back(d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
